mem_wb_stage_pipe: RTL and testbench

//  Parametrised MEM->WB pipeline register with valid/ready handshake, flush and bubble handling.

---
 rtl/memwb_pkg.sv | 20 ++
 rtl/memwb_slot.sv | 41 ++++
 rtl/mem_wb_stage_pipe.sv | 106 ++++++++++
 tb/tb_mem_wb_stage_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types and default widths for the MEM->WB stage register.
package memwb_pkg;

  localparam int MEMWB_DATA_W     = 32;
  localparam int MEMWB_REG_ADDR_W = 4;

  // The stage registers hold entries as flat vectors packed in this field order.
  typedef struct packed {
    logic                        wb_en;
    logic                        mem_r_en;
    logic [MEMWB_DATA_W-1:0]     alu_result;
    logic [MEMWB_DATA_W-1:0]     mem_rdata;
    logic [MEMWB_REG_ADDR_W-1:0] dest;
  } memwb_entry_t;

  function automatic int memwb_entry_w(input int data_w, input int addr_w);
    return 2 + 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/memwb_slot.sv
// One valid flag plus entry register; clear wins over load.
module memwb_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/mem_wb_stage_pipe.sv
// MEM->WB stage register with valid/ready, flush and a pre-muxed write-back value.
// Define MEMWB_SKID_EN for a registered in_ready backed by a second (skid) slot.
module mem_wb_stage_pipe
  import memwb_pkg::*;
#(
  parameter int DATA_W     = MEMWB_DATA_W,
  parameter int REG_ADDR_W = MEMWB_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wb_en,
  input  logic                  in_mem_r_en,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_rdata,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wb_en,
  output logic                  out_mem_r_en,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_mem_rdata,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]     out_wb_data
);

  localparam int ENTRY_W = memwb_entry_w(DATA_W, REG_ADDR_W);

  logic [ENTRY_W-1:0] in_entry, main_d, main_data;
  logic               main_valid, main_load, main_clear;
  logic               accept, emit, held_wb_en;

  assign in_entry = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_rdata, in_dest};
  assign accept   = in_valid && in_ready;
  assign emit     = main_valid && out_ready;

`ifdef MEMWB_SKID_EN
  logic               skid_valid, skid_load, skid_clear;
  logic [ENTRY_W-1:0] skid_data;

  assign in_ready = !skid_valid;

  // A full skid implies in_ready=0, so a skid move and an accept never coincide.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_entry;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid) begin
      if (emit) begin
        main_load  = 1'b1;
        main_d     = skid_data;
        skid_clear = 1'b1;
      end
    end else if (accept) begin
      if (!main_valid || emit) main_load = 1'b1;
      else                     skid_load = 1'b1;
    end else if (emit) begin
      main_clear = 1'b1;
    end
  end

  memwb_slot #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_entry),
    .valid (skid_valid),
    .data  (skid_data)
  );
`else
  assign in_ready = out_ready || !main_valid;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = in_entry;
    if (flush)       main_clear = 1'b1;
    else if (accept) main_load  = 1'b1;
    else if (emit)   main_clear = 1'b1;
  end
`endif

  memwb_slot #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .data  (main_data)
  );

  assign {held_wb_en, out_mem_r_en, out_alu_result, out_mem_rdata, out_dest} = main_data;
  assign out_valid   = main_valid;
  assign out_wb_en   = held_wb_en && main_valid;
  assign out_wb_data = out_mem_r_en ? out_mem_rdata : out_alu_result;

endmodule

// File: tb/tb_mem_wb_stage_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a FIFO reference model.
module tb_mem_wb_stage_pipe;

`ifdef MEMWB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_wb_en, in_mem_r_en;
  logic [31:0] in_alu_result, in_mem_rdata;
  logic [3:0]  in_dest;
  logic        out_valid, out_ready, out_wb_en, out_mem_r_en;
  logic [31:0] out_alu_result, out_mem_rdata, out_wb_data;
  logic [3:0]  out_dest;

  always #5 clk = ~clk;

  mem_wb_stage_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wb_en       (in_wb_en),
    .in_mem_r_en    (in_mem_r_en),
    .in_alu_result  (in_alu_result),
    .in_mem_rdata   (in_mem_rdata),
    .in_dest        (in_dest),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_wb_en      (out_wb_en),
    .out_mem_r_en   (out_mem_r_en),
    .out_alu_result (out_alu_result),
    .out_mem_rdata  (out_mem_rdata),
    .out_dest       (out_dest),
    .out_wb_data    (out_wb_data)
  );

  typedef struct {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [3:0]  dst;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare outputs with the model, then advance one clock with the given inputs.
  task automatic cycle(input logic iv, input logic wb, input logic mr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [3:0] dst, input logic ordy,
                       input logic fl);
    logic exp_ready;
    ent_t e;
    in_valid = iv; in_wb_en = wb; in_mem_r_en = mr; in_alu_result = alu;
    in_mem_rdata = rd; in_dest = dst; out_ready = ordy; flush = fl;
    #1;
    exp_ready = SKID ? (q.size() < 2) : (ordy || q.size() == 0);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_wb_en", out_wb_en, q[0].wb);
      check("out_mem_r_en", out_mem_r_en, q[0].mr);
      check("out_alu_result", out_alu_result, q[0].alu);
      check("out_mem_rdata", out_mem_rdata, q[0].rd);
      check("out_dest", out_dest, q[0].dst);
      check("out_wb_data", out_wb_data, q[0].mr ? q[0].rd : q[0].alu);
    end else begin
      check("bubble_wb_en", out_wb_en, 1'b0);
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && exp_ready) begin
        e.wb = wb; e.mr = mr; e.alu = alu; e.rd = rd; e.dst = dst;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wb_en = 1'b0; in_mem_r_en = 1'b0;
    in_alu_result = '0; in_mem_rdata = '0; in_dest = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_wb_data", out_wb_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming: dests 1..8 back to back
    for (int i = 1; i <= 8; i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h100 + i, 32'h200 + i, 4'(i), 1'b1, 1'b0);
    check("stream_last_dest", out_dest, 4'd8);
    idle(1'b1);

    // Load mux both ways
    cycle(1'b1, 1'b1, 1'b1, 32'h1111, 32'hABCD, 4'd3, 1'b1, 1'b0);
    check("ld_mux_load", out_wb_data, 32'hABCD);
    cycle(1'b1, 1'b1, 1'b0, 32'h1111, 32'hABCD, 4'd3, 1'b1, 1'b0);
    check("ld_mux_alu", out_wb_data, 32'h1111);
    idle(1'b1);

    // Backpressure: five stalled cycles with offers pending
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 1'b1, i[0], 32'h300 + i, 32'h400 + i, 4'(9 + i), 1'b0, 1'b0);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_dest_held", out_dest, 4'd9);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush with all slots full and an offer in flight
    for (int i = 0; i < CAP; i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h500 + i, 32'h0, 4'(2 + i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h0, 4'd15, 1'b1, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_wb_en", out_wb_en, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Bubble: wb_en asserted without in_valid
    cycle(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 4'd7, 1'b1, 1'b0);
    check("bubble_no_write", out_wb_en, 1'b0);
    idle(1'b1);

    // Reset with entries held, mid-cycle
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 1'b1, 32'h600 + i, 32'h700 + i, 4'(4 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_wb_en", out_wb_en, 1'b0);
    check("arst_alu", out_alu_result, 32'h0);
    check("arst_rdata", out_mem_rdata, 32'h0);
    check("arst_dest", out_dest, 4'h0);
    check("arst_mem_r_en", out_mem_r_en, 1'b0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 24) == 0));
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
